game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level game sequencer. Drives the 2-bit `game_state` bus and the display `mode` bit consumed by the score counter.
- Derives the obstacle speed level from the running score, tracks the session best score, and flags a new record with a blinking display enable.
- Sits between the button/collision sources and the score-counter and seven-segment display datapath.

Parameters:
- END_HOLD_TICKS, 90, game_clk ticks in END during which start presses are ignored.
- RESET_TICKS, 2, ticks spent in RESET before returning to INIT (must be >= 1).
- SPEED_STEP, 100, score points per speed level.
- MAX_LEVEL, 7, saturation value of speed_level (must be <= 7).
- BLINK_TICKS, 15, half-period of display_blank toggling during a new-record END.

Ports:
- game_clk  in  1  game tick clock.
- rst  in  1  synchronous reset, active-high.
- start_btn  in  1  debounced, synchronized start/jump button level.
- collision  in  1  dino/obstacle overlap, level.
- score  in  14  current score from the score counter (0..9999).
- game_state  out  2  INIT=0, START=1, END=2, RESET=3.
- mode  out  1  0 = display score, 1 = display high score.
- speed_level  out  3  obstacle speed index.
- best_score  out  14  highest score this power-on.
- new_record  out  1  last finished run beat best_score.
- display_blank  out  1  1 = blank the seven-segment display.

Behaviour:
- All state and outputs are registered on posedge game_clk.
- Reset is synchronous, active-high. While rst=1, at the next edge:
  - game_state=INIT, mode=1, speed_level=0, best_score=0, new_record=0, display_blank=0.
  - Internal hold/blink counters = 0, btn_q = 0.
- Press detection: press = start_btn & ~btn_q, where btn_q is start_btn registered. A held button yields exactly one press.
- INIT:
  - mode=1, speed_level=0, display_blank=0. collision is ignored.
  - On press: next state START, clear new_record.
- START:
  - mode=0. Press is ignored.
  - speed_level <= min(score / SPEED_STEP, MAX_LEVEL), registered, so it lags score by one tick.
  - collision=1: next state END. Collision takes priority over a simultaneous press.
  - On the START->END edge, if score > best_score: best_score <= score and new_record <= 1. Otherwise best_score and new_record are unchanged. An equal score is not a record.
  - hold_cnt <= 0 and blink_cnt <= 0 on entry to END.
- END:
  - speed_level is held. collision is ignored, and a sustained collision does not re-trigger the best_score update.
  - hold_cnt increments each tick and saturates at END_HOLD_TICKS.
  - mode=0 while hold_cnt < END_HOLD_TICKS, then mode=1.
  - If new_record=1:
    - blink_cnt counts 0..BLINK_TICKS-1 and wraps.
    - display_blank toggles on each wrap.
  - If new_record=0: display_blank=0.
  - A press while hold_cnt < END_HOLD_TICKS is ignored.
  - A press while hold_cnt == END_HOLD_TICKS: next state RESET.
- RESET:
  - mode=0, speed_level=0, display_blank=0.
  - rst_cnt counts RESET_TICKS ticks, then next state INIT. The score counter zeroes score during this window.
  - Presses are ignored. new_record is retained until the next START entry.
- Latency: a press or collision sampled at edge N appears on game_state after edge N. Arithmetic on score is unsigned 14-bit.
- rst asserted in any state, mid-hold or mid-blink, returns to the full reset values on the next edge. This includes clearing best_score.
- score=9999 gives speed_level = min(99, MAX_LEVEL) = MAX_LEVEL. No overflow is possible.

Test Plan:
- Reset then hold start_btn high for 5 ticks: game_state goes INIT->START exactly once, one tick after the rising edge; new_record=0; mode=0.
- In START, sweep score 0, 99, 100, 250, 799, 9999 (defaults): speed_level one tick later is 0, 0, 1, 2, 7, 7.
- First run: collision with score=42 -> END; best_score=42, new_record=1. display_blank toggles every 15 ticks, mode=1 after 90 ticks. Press at tick 89 is ignored; press at tick 91 gives RESET, then INIT 2 ticks later.
- Second run: collision with score=42 and best_score=42 -> new_record=0, display_blank stays 0, best_score stays 42.
- Collision and rising start_btn in the same START tick -> END; collision held high for 200 ticks -> best_score updated once, state stays END.
- Assert rst for 1 tick in END with hold_cnt=50 and display_blank=1 -> next tick INIT, best_score=0, new_record=0, display_blank=0, mode=1.

Source files
------------

// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: groups the game sequencer's data-side signals.
//   start_btn     - debounced start/jump button level (into sequencer)
//   collision     - dino/obstacle overlap level (into sequencer)
//   score         - current score, 0..9999 (into sequencer)
//   game_state    - INIT=0, START=1, END=2, RESET=3 (from sequencer)
//   mode          - 0 = show score, 1 = show high score (from sequencer)
//   speed_level   - obstacle speed index (from sequencer)
//   best_score    - best score since power-on (from sequencer)
//   new_record    - last finished run set a new best (from sequencer)
//   display_blank - 1 = blank the seven-segment display (from sequencer)
// The master modport is the sequencer itself; slave is its environment.
interface game_flow_ctrl_if;
  logic        start_btn;
  logic        collision;
  logic [13:0] score;
  logic [1:0]  game_state;
  logic        mode;
  logic [2:0]  speed_level;
  logic [13:0] best_score;
  logic        new_record;
  logic        display_blank;

  modport master (
    input  start_btn, collision, score,
    output game_state, mode, speed_level, best_score, new_record, display_blank
  );

  modport slave (
    output start_btn, collision, score,
    input  game_state, mode, speed_level, best_score, new_record, display_blank
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer.
// Walks INIT -> START -> END -> RESET -> INIT, derives the speed level from
// the running score, keeps the session best score and blinks the display
// when a finished run sets a new record.
//   game_clk - game tick clock
//   rst      - synchronous reset, active-high
//   bus      - game_flow_ctrl_if.master (button, collision, score in;
//              state, mode, speed, best score, record, blank out)
module game_flow_ctrl #(
  parameter int unsigned END_HOLD_TICKS = 90,
  parameter int unsigned RESET_TICKS    = 2,
  parameter int unsigned SPEED_STEP     = 100,
  parameter int unsigned MAX_LEVEL      = 7,
  parameter int unsigned BLINK_TICKS    = 15
) (
  input  logic             game_clk,
  input  logic             rst,
  game_flow_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_START = 2'd1,
    ST_END   = 2'd2,
    ST_RESET = 2'd3
  } state_t;

  // Counter widths always at least one bit, even for degenerate parameters.
  localparam int HOLD_W  = $clog2(END_HOLD_TICKS + 2);
  localparam int BLINK_W = $clog2(BLINK_TICKS + 2);
  localparam int RST_W   = $clog2(RESET_TICKS + 2);

  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(END_HOLD_TICKS);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RESET_TICKS - 1);

  state_t              state_q;
  logic                mode_q;
  logic [2:0]          speed_q;
  logic [13:0]         best_q;
  logic                new_rec_q;
  logic                blank_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [BLINK_W-1:0]  blink_cnt_q;
  logic [RST_W-1:0]    rst_cnt_q;
  logic                btn_q;

  logic                press;
  logic [13:0]         lvl_raw;
  logic [2:0]          speed_d;
  logic [HOLD_W-1:0]   hold_cnt_d;
  logic                blink_wrap;

  // NOTE: every signal assigned here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    press      = bus.start_btn & ~btn_q;
    lvl_raw    = bus.score / 14'(SPEED_STEP);
    speed_d    = (lvl_raw > 14'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : lvl_raw[2:0];
    hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
    blink_wrap = (blink_cnt_q == BLINK_LAST);
  end

  // NOTE: state uses non-blocking assignments only; where two assignments hit
  // the same register in one branch, the later one intentionally wins.
  always_ff @(posedge game_clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      mode_q      <= 1'b1;
      speed_q     <= '0;
      best_q      <= '0;
      new_rec_q   <= 1'b0;
      blank_q     <= 1'b0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      rst_cnt_q   <= '0;
      btn_q       <= 1'b0;
    end else begin
      btn_q <= bus.start_btn;
      unique case (state_q)
        ST_INIT: begin
          mode_q  <= 1'b1;
          speed_q <= '0;
          blank_q <= 1'b0;
          if (press) begin
            state_q   <= ST_START;
            mode_q    <= 1'b0;
            new_rec_q <= 1'b0;
          end
        end

        ST_START: begin
          mode_q  <= 1'b0;
          blank_q <= 1'b0;
          speed_q <= speed_d;
          // Collision wins over a simultaneous press; presses are ignored here.
          if (bus.collision) begin
            state_q     <= ST_END;
            hold_cnt_q  <= '0;
            blink_cnt_q <= '0;
            if (bus.score > best_q) begin
              best_q    <= bus.score;
              new_rec_q <= 1'b1;
            end
          end
        end

        ST_END: begin
          hold_cnt_q <= hold_cnt_d;
          mode_q     <= (hold_cnt_d == HOLD_MAX);
          if (new_rec_q) begin
            blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
            if (blink_wrap) blank_q <= ~blank_q;
          end else begin
            blank_q <= 1'b0;
          end
          // Presses only count once the hold window has fully elapsed.
          if (press && (hold_cnt_q == HOLD_MAX)) begin
            state_q   <= ST_RESET;
            rst_cnt_q <= '0;
            mode_q    <= 1'b0;
            speed_q   <= '0;
            blank_q   <= 1'b0;
          end
        end

        ST_RESET: begin
          mode_q  <= 1'b0;
          speed_q <= '0;
          blank_q <= 1'b0;
          if (rst_cnt_q == RST_LAST) begin
            state_q <= ST_INIT;
            mode_q  <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + RST_W'(1);
          end
        end

        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign bus.game_state    = state_q;
  assign bus.mode          = mode_q;
  assign bus.speed_level   = speed_q;
  assign bus.best_score    = best_q;
  assign bus.new_record    = new_rec_q;
  assign bus.display_blank = blank_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed scenarios plus randomized stimulus for
// game_flow_ctrl, compared each tick against a tick-counting reference model.
module tb_game_flow_ctrl;

  localparam int END_HOLD = 90;
  localparam int RST_T    = 2;
  localparam int STEP     = 100;
  localparam int MAXL     = 7;
  localparam int BLINK    = 15;

  logic game_clk = 1'b0;
  logic rst      = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  game_flow_ctrl_if bus_if ();

  game_flow_ctrl #(
    .END_HOLD_TICKS(END_HOLD),
    .RESET_TICKS   (RST_T),
    .SPEED_STEP    (STEP),
    .MAX_LEVEL     (MAXL),
    .BLINK_TICKS   (BLINK)
  ) dut (
    .game_clk(game_clk),
    .rst     (rst),
    .bus     (bus_if)
  );

  always #5 game_clk = ~game_clk;

  // Reference model: phase plus "ticks since entering the phase".
  int m_st;        // 0 INIT, 1 START, 2 END, 3 RESET
  int m_end_t;     // edges elapsed since entering END
  int m_rst_t;     // edges elapsed since entering RESET
  int m_spd;
  int m_best;
  bit m_nr;
  bit m_btn_prev;
  bit m_mode;
  bit m_blank;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit press;
    int sc;
    sc = int'(bus_if.score);
    if (rst) begin
      m_st = 0; m_spd = 0; m_best = 0; m_nr = 0;
      m_end_t = 0; m_rst_t = 0; m_btn_prev = 0;
    end else begin
      press      = bus_if.start_btn && !m_btn_prev;
      m_btn_prev = bus_if.start_btn;
      case (m_st)
        0: if (press) begin m_st = 1; m_nr = 0; end
        1: begin
          m_spd = (sc / STEP > MAXL) ? MAXL : sc / STEP;
          if (bus_if.collision) begin
            m_st = 2; m_end_t = 0;
            if (sc > m_best) begin m_best = sc; m_nr = 1; end
          end
        end
        2: begin
          if (press && m_end_t >= END_HOLD) begin
            m_st = 3; m_rst_t = 0;
          end else begin
            m_end_t++;
          end
        end
        default: begin
          m_rst_t++;
          if (m_rst_t == RST_T) m_st = 0;
        end
      endcase
    end
    if (m_st == 0 || m_st == 3) m_spd = 0;
    m_mode  = (m_st == 0) || (m_st == 2 && m_end_t >= END_HOLD);
    m_blank = (m_st == 2 && m_nr) ? bit'((m_end_t / BLINK) % 2) : 1'b0;
  endtask

  task automatic compare_all();
    check("game_state",    32'(bus_if.game_state),    32'(m_st));
    check("mode",          32'(bus_if.mode),          32'(m_mode));
    check("speed_level",   32'(bus_if.speed_level),   32'(m_spd));
    check("best_score",    32'(bus_if.best_score),    32'(m_best));
    check("new_record",    32'(bus_if.new_record),    32'(m_nr));
    check("display_blank", 32'(bus_if.display_blank), 32'(m_blank));
  endtask

  task automatic cycle(input logic b, input logic c, input logic [13:0] s, input logic r);
    bus_if.start_btn = b;
    bus_if.collision = c;
    bus_if.score     = s;
    rst              = r;
    @(posedge game_clk);
    model_step();
    @(negedge game_clk);
    compare_all();
  endtask

  initial begin
    logic [13:0] sweep_s [6];
    int          sweep_e [6];
    logic        rb;
    logic [13:0] rs;
    sweep_s = '{14'd0, 14'd99, 14'd100, 14'd250, 14'd799, 14'd9999};
    sweep_e = '{0, 0, 1, 2, 7, 7};

    bus_if.start_btn = 1'b0;
    bus_if.collision = 1'b0;
    bus_if.score     = '0;

    // Reset and idle.
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("reset_mode", 32'(bus_if.mode), 32'd1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Held button: exactly one INIT->START.
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    check("held_start_state", 32'(bus_if.game_state), 32'd1);
    check("held_start_mode",  32'(bus_if.mode),       32'd0);
    cycle(0, 0, 0, 0);

    // Speed sweep in START.
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, sweep_s[i], 0);
      check("speed_sweep", 32'(bus_if.speed_level), 32'(sweep_e[i]));
    end

    // First run: record at 42, blink, hold window, RESET, INIT.
    cycle(0, 1, 14'd42, 0);
    check("run1_best", 32'(bus_if.best_score), 32'd42);
    check("run1_rec",  32'(bus_if.new_record), 32'd1);
    for (int i = 0; i < 88; i++) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);  // early press, ignored
    check("early_press", 32'(bus_if.game_state), 32'd2);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("hold_mode", 32'(bus_if.mode), 32'd1);
    cycle(1, 0, 0, 0);
    check("late_press", 32'(bus_if.game_state), 32'd3);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("reset_to_init", 32'(bus_if.game_state), 32'd0);

    // Second run: equal score is not a record.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 14'd42, 0);
    cycle(0, 1, 14'd42, 0);
    check("run2_rec",  32'(bus_if.new_record), 32'd0);
    check("run2_best", 32'(bus_if.best_score), 32'd42);
    for (int i = 0; i < 95; i++) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Collision together with a rising press, then a long collision.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 14'd100, 0);
    cycle(1, 1, 14'd100, 0);
    check("coll_press_state", 32'(bus_if.game_state), 32'd2);
    for (int i = 0; i < 200; i++) cycle(0, 1, 14'd500, 0);
    check("long_coll_best",  32'(bus_if.best_score), 32'd100);
    check("long_coll_state", 32'(bus_if.game_state), 32'd2);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Record run, then reset mid-hold with the display blanked.
    cycle(1, 0, 0, 0);
    cycle(0, 1, 14'd300, 0);
    for (int i = 0; i < 50; i++) cycle(0, 0, 0, 0);
    check("blank_at_50", 32'(bus_if.display_blank), 32'd1);
    cycle(0, 0, 0, 1);
    check("rst_end_state", 32'(bus_if.game_state),    32'd0);
    check("rst_end_best",  32'(bus_if.best_score),    32'd0);
    check("rst_end_blank", 32'(bus_if.display_blank), 32'd0);
    check("rst_end_mode",  32'(bus_if.mode),          32'd1);

    // Randomized traffic.
    rb = 1'b0;
    rs = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      if ($urandom_range(0, 3) == 0) rs = 14'($urandom_range(0, 9999));
      cycle(rb, ($urandom_range(0, 15) == 0), rs, ($urandom_range(0, 399) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
